// File: rtl/sw_pe_affine_tb_pos.sv
// Smith-Waterman / Needleman-Wunsch systolic processing element with affine
// gaps. Computes one query row's M/I cells and tracks the running high score
// with its (row, col) position for the traceback start.
//
// Handshake: en_in is held high for a whole target stream, one cell per clock.
// en_out/data_out are en_in/data_in delayed one clock. vld pulses for one
// cycle after en_out falls; High_out/Hrow_out/Hcol_out are final while it is
// high and are held until the first cycle of the next run.
module sw_pe_affine_tb_pos #(
    parameter int SCORE_WIDTH = 12,
    parameter int BASE_WIDTH  = 2,
    parameter int IDX_WIDTH   = 10,
    parameter int PE_INDEX    = 0,
    parameter int GLOBAL      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_in,
    input  logic [BASE_WIDTH-1:0]  data_in,
    input  logic [BASE_WIDTH-1:0]  query,
    input  logic [SCORE_WIDTH-1:0] M_in,
    input  logic [SCORE_WIDTH-1:0] I_in,
    input  logic [SCORE_WIDTH-1:0] High_in,
    input  logic [IDX_WIDTH-1:0]   Hrow_in,
    input  logic [IDX_WIDTH-1:0]   Hcol_in,
    input  logic [SCORE_WIDTH-1:0] match,
    input  logic [SCORE_WIDTH-1:0] mismatch,
    input  logic [SCORE_WIDTH-1:0] gap_open,
    input  logic [SCORE_WIDTH-1:0] gap_extend,
    output logic [BASE_WIDTH-1:0]  data_out,
    output logic [SCORE_WIDTH-1:0] M_out,
    output logic [SCORE_WIDTH-1:0] I_out,
    output logic [SCORE_WIDTH-1:0] High_out,
    output logic [IDX_WIDTH-1:0]   Hrow_out,
    output logic [IDX_WIDTH-1:0]   Hcol_out,
    output logic                   en_out,
    output logic                   vld
);
    localparam int SW = SCORE_WIDTH;
    localparam int XW = SCORE_WIDTH + 2;
    localparam logic [SW-1:0]        ZERO   = {1'b1, {(SW-1){1'b0}}};
    localparam logic [SW-1:0]        SMAX   = {SW{1'b1}};
    localparam logic [IDX_WIDTH-1:0] CMAX   = {IDX_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0] ROW_ID = IDX_WIDTH'(PE_INDEX);

    typedef enum logic {S_IDLE, S_CALC} score_state_t;
    typedef enum logic {H_IDLE, H_CALC} high_state_t;

    score_state_t score_state;
    high_state_t  high_state;

    logic [SW-1:0]        m_diag, i_diag;
    logic [IDX_WIDTH-1:0] col;

    // Biased scores are unsigned; widen with zero fill so sums stay positive.
    function automatic logic signed [XW-1:0] widen_score(input logic [SW-1:0] v);
        return $signed({2'b00, v});
    endfunction

    // Penalties are two's complement; widen with sign fill.
    function automatic logic signed [XW-1:0] widen_pen(input logic [SW-1:0] p);
        return $signed({{2{p[SW-1]}}, p});
    endfunction

    // Clamp a widened sum back into [0, 2**SW-1].
    function automatic logic [SW-1:0] sat(input logic signed [XW-1:0] v);
        if (v[XW-1]) return '0;
        if (v[XW-2:SW] != 2'b00) return SMAX;
        return v[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] umax(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic                   first_cell;
    logic [SW-1:0]          m_up, i_up, m_dg, i_dg, s_pen, m_sat, m_next, i_next;
    logic signed [XW-1:0]   m_sum, i_open, i_ext;

    // Cell recurrence; the first cell of a run sees ZERO above and on the diagonal.
    always_comb begin
        first_cell = (score_state == S_IDLE);
        m_up   = first_cell ? ZERO : M_out;
        i_up   = first_cell ? ZERO : I_out;
        m_dg   = first_cell ? ZERO : m_diag;
        i_dg   = first_cell ? ZERO : i_diag;
        s_pen  = (data_in == query) ? match : mismatch;
        m_sum  = widen_score(umax(m_dg, i_dg)) + widen_pen(s_pen);
        i_open = widen_score(umax(M_in, m_up)) + widen_pen(gap_open) + widen_pen(gap_extend);
        i_ext  = widen_score(umax(I_in, i_up)) + widen_pen(gap_extend);
        m_sat  = sat(m_sum);
        m_next = ((GLOBAL == 0) && (m_sat < ZERO)) ? ZERO : m_sat;
        i_next = sat((i_open > i_ext) ? i_open : i_ext);
    end

    // Score FSM: registers one cell per enabled clock, clears to ZERO while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_state <= S_IDLE;
            M_out       <= ZERO;
            I_out       <= ZERO;
            m_diag      <= ZERO;
            i_diag      <= ZERO;
            data_out    <= '0;
            en_out      <= 1'b0;
        end else begin
            en_out <= en_in;
            if (en_in) data_out <= data_in;
            case (score_state)
                S_IDLE: begin
                    if (en_in) begin
                        M_out       <= m_next;
                        I_out       <= i_next;
                        m_diag      <= M_in;
                        i_diag      <= I_in;
                        score_state <= S_CALC;
                    end else begin
                        M_out  <= ZERO;
                        I_out  <= ZERO;
                        m_diag <= ZERO;
                        i_diag <= ZERO;
                    end
                end
                S_CALC: begin
                    if (en_in) begin
                        M_out  <= m_next;
                        I_out  <= i_next;
                        m_diag <= M_in;
                        i_diag <= I_in;
                    end else begin
                        score_state <= S_IDLE;
                    end
                end
                default: score_state <= S_IDLE;
            endcase
        end
    end

    logic [SW-1:0]        own, cand_score;
    logic [IDX_WIDTH-1:0] cand_row, cand_col, col_inc;

    // Candidate high: the left neighbour wins ties against this PE's own score.
    always_comb begin
        own     = umax(M_out, I_out);
        col_inc = (col == CMAX) ? col : col + 1'b1;
        if (High_in >= own) begin
            cand_score = High_in;
            cand_row   = Hrow_in;
            cand_col   = Hcol_in;
        end else begin
            cand_score = own;
            cand_row   = ROW_ID;
            cand_col   = col;
        end
    end

    // High FSM: follows en_out, col indexes the cell currently on M_out/I_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_state <= H_IDLE;
            High_out   <= ZERO;
            Hrow_out   <= '0;
            Hcol_out   <= '0;
            col        <= '0;
            vld        <= 1'b0;
        end else begin
            vld <= 1'b0;
            case (high_state)
                H_IDLE: begin
                    if (en_out) begin
                        High_out   <= cand_score;
                        Hrow_out   <= cand_row;
                        Hcol_out   <= cand_col;
                        col        <= col_inc;
                        high_state <= H_CALC;
                    end
                end
                H_CALC: begin
                    if (en_out) begin
                        if (cand_score > High_out) begin
                            High_out <= cand_score;
                            Hrow_out <= cand_row;
                            Hcol_out <= cand_col;
                        end
                        col <= col_inc;
                    end else begin
                        vld        <= 1'b1;
                        col        <= '0;
                        high_state <= H_IDLE;
                    end
                end
                default: high_state <= H_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_pe_affine_tb_pos.sv
// Bench for sw_pe_affine_tb_pos: a local-mode PE (row 5) and a global-mode PE
// (row 0) share all inputs. Directed vector table, saturation and abort
// sequences, then random streams checked against a per-run reference model.
module tb_sw_pe_affine_tb_pos;
    localparam int Z = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic [1:0]  data_in, query;
    logic [11:0] m_in, i_in, high_in, match, mismatch, gap_open, gap_extend;
    logic [9:0]  hrow_in, hcol_in;

    logic [1:0]  data_out [2];
    logic [11:0] m_out [2];
    logic [11:0] i_out [2];
    logic [11:0] high_out [2];
    logic [9:0]  hrow_out [2];
    logic [9:0]  hcol_out [2];
    logic        en_out [2];
    logic        vld [2];

    int n_vec = 0;
    int n_err = 0;
    int run_id = 0;
    int pb_s [2];
    int pb_r [2];
    int pb_c [2];

    sw_pe_affine_tb_pos #(.SCORE_WIDTH(12), .BASE_WIDTH(2), .IDX_WIDTH(10),
                          .PE_INDEX(5), .GLOBAL(0)) dut_l (
        .clk(clk), .rst(rst), .en_in(en_in), .data_in(data_in), .query(query),
        .M_in(m_in), .I_in(i_in), .High_in(high_in), .Hrow_in(hrow_in), .Hcol_in(hcol_in),
        .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
        .data_out(data_out[0]), .M_out(m_out[0]), .I_out(i_out[0]), .High_out(high_out[0]),
        .Hrow_out(hrow_out[0]), .Hcol_out(hcol_out[0]), .en_out(en_out[0]), .vld(vld[0]));

    sw_pe_affine_tb_pos #(.SCORE_WIDTH(12), .BASE_WIDTH(2), .IDX_WIDTH(10),
                          .PE_INDEX(0), .GLOBAL(1)) dut_g (
        .clk(clk), .rst(rst), .en_in(en_in), .data_in(data_in), .query(query),
        .M_in(m_in), .I_in(i_in), .High_in(high_in), .Hrow_in(hrow_in), .Hcol_in(hcol_in),
        .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
        .data_out(data_out[1]), .M_out(m_out[1]), .I_out(i_out[1]), .High_out(high_out[1]),
        .Hrow_out(hrow_out[1]), .Hcol_out(hcol_out[1]), .en_out(en_out[1]), .vld(vld[1]));

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic set_pen(input int pm, input int pmm, input int pgo, input int pge);
        match = 12'(pm); mismatch = 12'(pmm); gap_open = 12'(pgo); gap_extend = 12'(pge);
    endtask

    // One clock with the PE disabled; outputs must sit at ZERO, high held.
    task automatic idle_cycle();
        en_in = 1'b0;
        data_in = 2'($urandom); m_in = 12'($urandom); i_in = 12'($urandom);
        high_in = 12'($urandom); hrow_in = 10'($urandom); hcol_in = 10'($urandom);
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("idle g%0d en_out", g), en_out[g], 0);
            chk($sformatf("idle g%0d vld", g), vld[g], 0);
            chk($sformatf("idle g%0d M_out", g), m_out[g], Z);
            chk($sformatf("idle g%0d High_out", g), high_out[g], pb_s[g]);
            chk($sformatf("idle g%0d Hcol_out", g), hcol_out[g], pb_c[g]);
        end
    endtask

    // mode 0: random stream, mode 1: strictly rising ramp to saturate col.
    task automatic run_stream(input int len, input int mode);
        int d [1100];
        int mi [1100];
        int ii [1100];
        int hs [1100];
        int hr [1100];
        int hc [1100];
        int em [2][1100];
        int ei [2][1100];
        int rs [2][1100];
        int rr [2][1100];
        int rc [2][1100];
        int q, pm, pmm, pgo, pge, wide;
        int md, id, mup, iup, s, own, cs, cr, cc, bs, br, bc, xs, xr, xc;
        run_id++;
        wide = int'($urandom_range(0, 1));
        if (mode == 1) begin
            q = 0; pm = 1; pmm = -1; pgo = -3; pge = -1;
        end else if ($urandom_range(0, 3) == 0) begin
            q = int'($urandom_range(0, 3));
            pm = int'($urandom_range(0, 2047)); pmm = -int'($urandom_range(0, 2048));
            pgo = -int'($urandom_range(0, 2048)); pge = -int'($urandom_range(0, 2048));
        end else begin
            q = int'($urandom_range(0, 3));
            pm = int'($urandom_range(0, 8)); pmm = -int'($urandom_range(0, 8));
            pgo = int'($urandom_range(0, 10)) - 8; pge = -int'($urandom_range(0, 4));
        end
        for (int k = 0; k < len; k++) begin
            if (mode == 1) begin
                d[k] = 0; mi[k] = 2048 + k; ii[k] = 2048 + k; hs[k] = 0; hr[k] = 0; hc[k] = 0;
            end else begin
                d[k]  = int'($urandom_range(0, 3));
                mi[k] = wide ? int'($urandom_range(0, 4095)) : int'($urandom_range(2000, 2100));
                ii[k] = wide ? int'($urandom_range(0, 4095)) : int'($urandom_range(2000, 2100));
                hs[k] = int'($urandom_range(1950, 2150));
                hr[k] = int'($urandom_range(0, 1023));
                hc[k] = int'($urandom_range(0, 1023));
            end
        end
        // Reference: score recurrence then high-score selection, per instance.
        for (int g = 0; g < 2; g++) begin
            bs = 0; br = 0; bc = 0;
            for (int k = 0; k < len; k++) begin
                md  = (k == 0) ? Z : mi[k-1];
                id  = (k == 0) ? Z : ii[k-1];
                mup = (k == 0) ? Z : em[g][k-1];
                iup = (k == 0) ? Z : ei[g][k-1];
                s   = (d[k] == q) ? pm : pmm;
                em[g][k] = clampi(maxi(md, id) + s);
                if (g == 0 && em[g][k] < Z) em[g][k] = Z;
                ei[g][k] = clampi(maxi(maxi(mi[k], mup) + pgo + pge, maxi(ii[k], iup) + pge));
                own = maxi(em[g][k], ei[g][k]);
                if (hs[k] >= own) begin
                    cs = hs[k]; cr = hr[k]; cc = hc[k];
                end else begin
                    cs = own; cr = (g == 0) ? 5 : 0; cc = (k > 1023) ? 1023 : k;
                end
                if (k == 0 || cs > bs) begin
                    bs = cs; br = cr; bc = cc;
                end
                rs[g][k] = bs; rr[g][k] = br; rc[g][k] = bc;
            end
        end
        query = 2'(q);
        set_pen(pm, pmm, pgo, pge);
        for (int c = 0; c <= len + 1; c++) begin
            en_in = (c < len);
            if (c < len) begin
                data_in = 2'(d[c]); m_in = 12'(mi[c]); i_in = 12'(ii[c]);
            end else begin
                data_in = 2'($urandom); m_in = 12'($urandom); i_in = 12'($urandom);
            end
            if (c >= 1 && c <= len) begin
                high_in = 12'(hs[c-1]); hrow_in = 10'(hr[c-1]); hcol_in = 10'(hc[c-1]);
            end else begin
                high_in = 12'($urandom); hrow_in = 10'($urandom); hcol_in = 10'($urandom);
            end
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                if (c < len) begin
                    chk($sformatf("r%0d c%0d g%0d en_out", run_id, c, g), en_out[g], 1);
                    chk($sformatf("r%0d c%0d g%0d data_out", run_id, c, g), data_out[g], d[c]);
                    chk($sformatf("r%0d c%0d g%0d M_out", run_id, c, g), m_out[g], em[g][c]);
                    chk($sformatf("r%0d c%0d g%0d I_out", run_id, c, g), i_out[g], ei[g][c]);
                end else if (c == len) begin
                    chk($sformatf("r%0d c%0d g%0d en_out", run_id, c, g), en_out[g], 0);
                    chk($sformatf("r%0d c%0d g%0d M_hold", run_id, c, g), m_out[g], em[g][len-1]);
                    chk($sformatf("r%0d c%0d g%0d I_hold", run_id, c, g), i_out[g], ei[g][len-1]);
                end else begin
                    chk($sformatf("r%0d c%0d g%0d M_zero", run_id, c, g), m_out[g], Z);
                    chk($sformatf("r%0d c%0d g%0d I_zero", run_id, c, g), i_out[g], Z);
                end
                chk($sformatf("r%0d c%0d g%0d vld", run_id, c, g), vld[g], (c == len + 1) ? 1 : 0);
                if (c == 0) begin
                    xs = pb_s[g]; xr = pb_r[g]; xc = pb_c[g];
                end else begin
                    xs = rs[g][(c - 1 < len - 1) ? c - 1 : len - 1];
                    xr = rr[g][(c - 1 < len - 1) ? c - 1 : len - 1];
                    xc = rc[g][(c - 1 < len - 1) ? c - 1 : len - 1];
                end
                chk($sformatf("r%0d c%0d g%0d High_out", run_id, c, g), high_out[g], xs);
                chk($sformatf("r%0d c%0d g%0d Hrow_out", run_id, c, g), hrow_out[g], xr);
                chk($sformatf("r%0d c%0d g%0d Hcol_out", run_id, c, g), hcol_out[g], xc);
            end
        end
        for (int g = 0; g < 2; g++) begin
            pb_s[g] = rs[g][len-1]; pb_r[g] = rr[g][len-1]; pb_c[g] = rc[g][len-1];
        end
    endtask

    typedef struct {
        int en, d, mi, ii, hs, hr, hc;
        int x_en, x_m, x_i, x_mg, x_vld, x_hs, x_hr, x_hc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // query A, match +2, mismatch -1, gap_open -3, gap_extend -1; checks on the local PE (row 5)
        //            en d  M_in  I_in  Hi   Hr Hc  | en M    I     Mglob vld High Hr Hc
        tbl[0]  = '{1, 0, 2048, 2048, 2048, 0, 0,  1, 2050, 2047, 2050, 0, 2048, 0, 0};
        tbl[1]  = '{1, 0, 2048, 2048, 2048, 0, 0,  1, 2050, 2047, 2050, 0, 2050, 5, 0};
        tbl[2]  = '{1, 1, 2048, 2048, 2048, 0, 0,  1, 2048, 2047, 2047, 0, 2050, 5, 0};
        tbl[3]  = '{0, 0, 2048, 2048, 2048, 0, 0,  0, 2048, 2047, 2047, 0, 2050, 5, 0};
        tbl[4]  = '{0, 0, 2048, 2048, 2048, 0, 0,  0, 2048, 2048, 2048, 1, 2050, 5, 0};
        tbl[5]  = '{0, 0, 2048, 2048, 2048, 0, 0,  0, 2048, 2048, 2048, 0, 2050, 5, 0};
        tbl[6]  = '{1, 1, 2048, 2048, 2048, 0, 0,  1, 2048, 2047, 2047, 0, 2050, 5, 0};
        tbl[7]  = '{0, 0, 2048, 2048, 2048, 0, 0,  0, 2048, 2047, 2047, 0, 2048, 0, 0};
        tbl[8]  = '{0, 0, 2048, 2048, 2048, 0, 0,  0, 2048, 2048, 2048, 1, 2048, 0, 0};
        tbl[9]  = '{1, 0, 2048, 2048, 2048, 0, 0,  1, 2050, 2047, 2050, 0, 2048, 0, 0};
        tbl[10] = '{0, 0, 2048, 2048, 2050, 1, 3,  0, 2050, 2047, 2050, 0, 2050, 1, 3};
        tbl[11] = '{0, 0, 2048, 2048, 2048, 0, 0,  0, 2048, 2048, 2048, 1, 2050, 1, 3};
        tbl[12] = '{0, 0, 2048, 2048, 2048, 0, 0,  0, 2048, 2048, 2048, 0, 2050, 1, 3};

        // Reset
        rst = 1'b1; en_in = 1'b0; data_in = '0; query = '0; m_in = '0; i_in = '0;
        high_in = '0; hrow_in = '0; hcol_in = '0;
        set_pen(2, -1, -3, -1);
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset g%0d M_out", g), m_out[g], Z);
            chk($sformatf("reset g%0d I_out", g), i_out[g], Z);
            chk($sformatf("reset g%0d High_out", g), high_out[g], Z);
            chk($sformatf("reset g%0d Hrow_out", g), hrow_out[g], 0);
            chk($sformatf("reset g%0d Hcol_out", g), hcol_out[g], 0);
            chk($sformatf("reset g%0d en_out", g), en_out[g], 0);
            chk($sformatf("reset g%0d vld", g), vld[g], 0);
            chk($sformatf("reset g%0d data_out", g), data_out[g], 0);
        end
        rst = 1'b0;

        // Directed table
        for (int r = 0; r < 13; r++) begin
            en_in = (tbl[r].en != 0); data_in = 2'(tbl[r].d);
            m_in = 12'(tbl[r].mi); i_in = 12'(tbl[r].ii);
            high_in = 12'(tbl[r].hs); hrow_in = 10'(tbl[r].hr); hcol_in = 10'(tbl[r].hc);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d en_out", r), en_out[0], tbl[r].x_en);
            chk($sformatf("tbl%0d M_out", r), m_out[0], tbl[r].x_m);
            chk($sformatf("tbl%0d I_out", r), i_out[0], tbl[r].x_i);
            chk($sformatf("tbl%0d M_out_global", r), m_out[1], tbl[r].x_mg);
            chk($sformatf("tbl%0d vld", r), vld[0], tbl[r].x_vld);
            chk($sformatf("tbl%0d vld_global", r), vld[1], tbl[r].x_vld);
            chk($sformatf("tbl%0d High_out", r), high_out[0], tbl[r].x_hs);
            chk($sformatf("tbl%0d Hrow_out", r), hrow_out[0], tbl[r].x_hr);
            chk($sformatf("tbl%0d Hcol_out", r), hcol_out[0], tbl[r].x_hc);
        end

        // Saturation: match +5 with M_in/I_in held at 4094
        set_pen(5, -1, -3, -1);
        query = 2'd0; m_in = 12'd4094; i_in = 12'd4094; high_in = '0; hrow_in = '0; hcol_in = '0;
        for (int c = 0; c < 4; c++) begin
            en_in = 1'b1; data_in = 2'd0;
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("sat c%0d g%0d M_out", c, g), m_out[g], (c == 0) ? 2053 : 4095);
                chk($sformatf("sat c%0d g%0d I_out", c, g), i_out[g], 4093);
            end
        end

        // Asynchronous reset in the middle of a clock, during CALC
        #3;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("abort g%0d M_out", g), m_out[g], Z);
            chk($sformatf("abort g%0d I_out", g), i_out[g], Z);
            chk($sformatf("abort g%0d High_out", g), high_out[g], Z);
            chk($sformatf("abort g%0d Hrow_out", g), hrow_out[g], 0);
            chk($sformatf("abort g%0d Hcol_out", g), hcol_out[g], 0);
            chk($sformatf("abort g%0d en_out", g), en_out[g], 0);
            chk($sformatf("abort g%0d vld", g), vld[g], 0);
        end
        en_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            pb_s[g] = Z; pb_r[g] = 0; pb_c[g] = 0;
        end
        repeat (4) idle_cycle();

        // Random streams, some back to back with the previous vld pulse
        for (int n = 0; n < 20; n++) begin
            run_stream(int'($urandom_range(1, 12)), 0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        run_stream(1030, 1);
        idle_cycle();
        for (int n = 0; n < 20; n++) begin
            run_stream(int'($urandom_range(1, 12)), 0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
